uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001: Parameter FPGA_clk_freq, default 50000000, clk frequency in Hz.
REQ-002: Parameter baudrate, default 115200, serial bit rate in bits/s.
REQ-003: Parameter FIFO_DEPTH, default 4, transmit FIFO entries; power of two, >= 2.
REQ-004: Derived constant CLKS_PER_BIT SHALL equal FPGA_clk_freq / baudrate, integer-truncated (434 at defaults).
REQ-005: clk  input  1  clock; all logic rising-edge.
REQ-006: rst  input  1  reset, synchronous, active-high.
REQ-007: i_TX_DV  input  1  write strobe; byte accepted when i_TX_DV and o_TX_Ready are both high on a clk edge.
REQ-008: i_TX_Byte  input  8  byte to transmit, sampled with i_TX_DV.
REQ-009: o_TX_Ready  output  1  FIFO not full.
REQ-010: o_TX_Serial  output  1  serial line, idle high, registered.
REQ-011: o_TX_Active  output  1  high while a frame is on the line (START_BIT through STOP_BIT).
REQ-012: o_TX_Done  output  1  single-cycle pulse when a frame's stop bit completes.
REQ-013: o_FIFO_Count  output  $clog2(FIFO_DEPTH)+1  bytes currently queued (0..FIFO_DEPTH).

Function
REQ-014: Frame SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), each held exactly CLKS_PER_BIT clk cycles.
REQ-015: FSM states SHALL be IDLE, START_BIT, DATA_BITS, STOP_BIT, CLEANUP; unreachable encodings return to IDLE.
REQ-016: IDLE: o_TX_Serial high; if o_FIFO_Count > 0, pop head byte into shift register and go to START_BIT; else stay.
REQ-017: START_BIT: o_TX_Serial low; after CLKS_PER_BIT cycles go to DATA_BITS with bit index 0.
REQ-018: DATA_BITS: o_TX_Serial = byte[index]; after CLKS_PER_BIT cycles increment index; after index 7 completes go to STOP_BIT.
REQ-019: STOP_BIT: o_TX_Serial high; after CLKS_PER_BIT cycles assert o_TX_Done for one cycle and go to CLEANUP.
REQ-020: CLEANUP: o_TX_Serial high, o_TX_Done low, go to IDLE next cycle.
REQ-021: Latency: byte written to empty FIFO with FSM in IDLE on edge N is popped on edge N+1; o_TX_Serial low from edge N+2.
REQ-022: Back-to-back queued frames SHALL be separated by exactly 2 extra high cycles (CLEANUP + IDLE pop) after the stop bit.
REQ-023: o_TX_Ready SHALL be low when o_FIFO_Count == FIFO_DEPTH; a write while full is ignored, FIFO contents and count unchanged.
REQ-024: Simultaneous write and pop in one cycle SHALL leave o_FIFO_Count unchanged and preserve order.
REQ-025: FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH; bytes SHALL transmit in write order.
REQ-026: i_TX_Byte changes after acceptance SHALL not affect the queued or in-flight byte.
REQ-027: Bit-period counter width SHALL be $clog2(CLKS_PER_BIT)+1 bits; it resets to 0 at every bit boundary.

Reset
REQ-028: rst SHALL force state IDLE, o_TX_Serial 1, o_TX_Active 0, o_TX_Done 0, o_FIFO_Count 0, o_TX_Ready 1, counters and pointers 0.
REQ-029: rst mid-frame SHALL abort the frame, drive line high next cycle, and discard all queued bytes; rst has priority over i_TX_DV.

Verification (FPGA_clk_freq=1000, baudrate=100, CLKS_PER_BIT=10, FIFO_DEPTH=4)
REQ-030: Write 0xA5 at idle -> line low from write+2 for 10 cycles, then 1,0,1,0,0,1,0,1 at 10 cycles each, high 10 cycles, o_TX_Done one pulse; 100-cycle frame.
REQ-031: Write 0x00 then 0xFF consecutively -> two frames in order, gap of 2 high cycles between stop bit end and second start bit.
REQ-032: Write 6 bytes 0x01..0x06 back-to-back while first frame starts -> o_TX_Ready low at count 4, extra write dropped, received bytes exactly those accepted, in order.
REQ-033: Assert rst during DATA_BITS with 2 bytes queued -> next cycle line high, count 0, Ready 1, no Done pulse, no further frames.
REQ-034: Write on the same cycle as an IDLE pop with count 1 -> count stays 1, both bytes transmitted in order.

Source files
------------

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small write-side byte FIFO.
// One frame = start bit, 8 data bits LSB first, stop bit, each CLKS_PER_BIT clocks.
module uart_tx #(
  parameter int FPGA_clk_freq = 50000000,
  parameter int baudrate      = 115200,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_TX_DV,
  input  logic [7:0]                  i_TX_Byte,
  output logic                        o_TX_Ready,
  output logic                        o_TX_Serial,
  output logic                        o_TX_Active,
  output logic                        o_TX_Done,
  output logic [$clog2(FIFO_DEPTH):0] o_FIFO_Count
);

  localparam int CLKS_PER_BIT = FPGA_clk_freq / baudrate;
  localparam int BIT_CNT_W    = $clog2(CLKS_PER_BIT) + 1;
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int FCNT_W       = $clog2(FIFO_DEPTH) + 1;

  localparam logic [BIT_CNT_W-1:0] BIT_LAST  = BIT_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [FCNT_W-1:0]    FIFO_FULL = FCNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_BIT = 3'd1,
    DATA_BITS = 3'd2,
    STOP_BIT  = 3'd3,
    CLEANUP   = 3'd4
  } state_t;

  state_t                 state_q,   state_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [7:0]             shift_q,   shift_d;
  logic                   serial_q,  serial_d;
  logic                   active_q,  active_d;
  logic                   done_q,    done_d;
  logic [PTR_W-1:0]       wr_ptr_q,  wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q,  rd_ptr_d;
  logic [FCNT_W-1:0]      count_q,   count_d;
  logic [7:0]             mem_q [FIFO_DEPTH];

  logic push;
  logic pop;
  logic bit_end;

  assign push    = i_TX_DV && (count_q != FIFO_FULL);
  assign pop     = (state_q == IDLE) && (count_q != '0);
  assign bit_end = (bit_cnt_q == BIT_LAST);

  // FIFO bookkeeping: pointers wrap naturally at the power-of-two depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + FCNT_W'(1);
      2'b01:   count_d = count_q - FCNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        bit_idx_d = '0;
        if (pop) begin
          shift_d = mem_q[rd_ptr_q];
          state_d = START_BIT;
        end
      end

      START_BIT: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = DATA_BITS;
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
        end
      end

      DATA_BITS: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP_BIT;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
        end
      end

      STOP_BIT: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          done_d    = 1'b1;
          state_d   = CLEANUP;
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
        end
      end

      CLEANUP: begin
        state_d = IDLE;
      end

      default: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
        bit_idx_d = '0;
      end
    endcase
  end

  // Line level and active flag are registered, so they trail the state by one cycle.
  always_comb begin
    serial_d = 1'b1;
    active_d = 1'b0;
    case (state_q)
      START_BIT: begin
        serial_d = 1'b0;
        active_d = 1'b1;
      end
      DATA_BITS: begin
        serial_d = shift_q[bit_idx_q];
        active_d = 1'b1;
      end
      STOP_BIT: begin
        serial_d = 1'b1;
        active_d = 1'b1;
      end
      default: begin
        serial_d = 1'b1;
        active_d = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      serial_q  <= 1'b1;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      serial_q  <= serial_d;
      active_q  <= active_d;
      done_q    <= done_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // NOTE: the storage array is not reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_q[wr_ptr_q] <= i_TX_Byte;
    end
  end

  assign o_TX_Ready   = (count_q != FIFO_FULL);
  assign o_TX_Serial  = serial_q;
  assign o_TX_Active  = active_q;
  assign o_TX_Done    = done_q;
  assign o_FIFO_Count = count_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frame-schedule reference model compared every cycle,
// plus literal waveform/decoder checks for the directed scenarios.
module tb_uart_tx;

  localparam int CLK_HZ = 1000;
  localparam int BAUD   = 100;
  localparam int DEPTH  = 4;
  localparam int CPB    = CLK_HZ / BAUD;
  localparam int FRAME  = 10 * CPB;
  localparam int CW     = $clog2(DEPTH) + 1;
  localparam int MAXC   = 20000;

  logic          clk = 1'b0;
  logic          rst;
  logic          dv;
  logic [7:0]    din;
  logic          ready;
  logic          serial;
  logic          active;
  logic          done;
  logic [CW-1:0] count;

  uart_tx #(
    .FPGA_clk_freq(CLK_HZ),
    .baudrate     (BAUD),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_TX_DV     (dv),
    .i_TX_Byte   (din),
    .o_TX_Ready  (ready),
    .o_TX_Serial (serial),
    .o_TX_Active (active),
    .o_TX_Done   (done),
    .o_FIFO_Count(count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: each accepted byte gets a scheduled frame start cycle.
  // A frame starting at cycle s occupies line cycles s..s+FRAME-1, is popped at s-1,
  // and the next frame can start no earlier than s+FRAME+2.
  typedef struct {
    logic [7:0] b;
    int         start;
  } rec_t;

  rec_t       pend[$];
  int         cyc        = 0;
  int         cur_start  = 0;
  int         last_start = -1000;
  logic [7:0] cur_byte   = 8'h00;
  bit         cur_valid  = 1'b0;
  bit         check_en   = 1'b0;
  int         cnt_before;
  int         s_new;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      pend.delete();
      cur_valid  = 1'b0;
      last_start = -1000;
      check_en   = 1'b1;
    end else begin
      cnt_before = pend.size();
      if (pend.size() != 0 && pend[0].start - 1 == cyc) begin
        cur_byte  = pend[0].b;
        cur_start = pend[0].start;
        cur_valid = 1'b1;
        void'(pend.pop_front());
      end
      if (dv && cnt_before < DEPTH) begin
        s_new = (cyc + 2 > last_start + FRAME + 2) ? cyc + 2 : last_start + FRAME + 2;
        pend.push_back('{b: din, start: s_new});
        last_start = s_new;
      end
    end
  end

  // Per-cycle compare against the model, plus history for the line decoder.
  logic          line_hist [MAXC];
  logic          done_hist [MAXC];
  logic          rdy_hist  [MAXC];
  logic [CW-1:0] cnt_hist  [MAXC];
  int            k_bit;
  logic          exp_ser;
  logic          exp_act;
  logic          exp_done;

  always @(negedge clk) begin
    if (cyc < MAXC) begin
      line_hist[cyc] = serial;
      done_hist[cyc] = done;
      rdy_hist[cyc]  = ready;
      cnt_hist[cyc]  = count;
    end
    if (check_en) begin
      exp_ser  = 1'b1;
      exp_act  = 1'b0;
      exp_done = 1'b0;
      if (cur_valid && cyc >= cur_start && cyc < cur_start + FRAME) begin
        k_bit   = (cyc - cur_start) / CPB;
        exp_act = 1'b1;
        if (k_bit == 0)      exp_ser = 1'b0;
        else if (k_bit <= 8) exp_ser = cur_byte[k_bit-1];
        if (cyc == cur_start + FRAME - 1) exp_done = 1'b1;
      end
      check("model_serial", 32'(serial), 32'(exp_ser));
      check("model_active", 32'(active), 32'(exp_act));
      check("model_done",   32'(done),   32'(exp_done));
      check("model_count",  32'(count),  32'(pend.size()));
      check("model_ready",  32'(ready),  32'(pend.size() < DEPTH));
    end
  end

  // Stimulus helpers; all are entered and left right after a falling edge.
  logic [7:0] bq[$];
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int         t_burst;

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic burst();
    t_burst = cyc + 1;
    foreach (bq[i]) begin
      dv  = 1'b1;
      din = bq[i];
      @(negedge clk);
    end
    dv  = 1'b0;
    din = 8'($urandom);
  endtask

  task automatic decode(input int from, input int to);
    int i;
    logic [7:0] v;
    rx_q.delete();
    i = from;
    while (i + FRAME <= to && i + FRAME < MAXC) begin
      if (line_hist[i] == 1'b0) begin
        for (int b = 0; b < 8; b++) v[b] = line_hist[i + CPB * (b + 1) + CPB / 2];
        rx_q.push_back(v);
        i = i + FRAME;
      end else begin
        i = i + 1;
      end
    end
  endtask

  task automatic check_rx(input string name);
    check({name, "_frames"}, 32'(rx_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (i < rx_q.size()) check(name, 32'(rx_q[i]), 32'(exp_q[i]));
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, required completion before time limit");
    $fatal(1, "watchdog expired");
  end

  logic [9:0] a5_lit;
  logic [7:0] rb_a;
  logic [7:0] rb_b;
  int t, tr, r, n, gap, budget, ones, dones;

  initial begin
    rst = 1'b1;
    dv  = 1'b0;
    din = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_serial", 32'(serial), 32'd1);
    check("reset_active", 32'(active), 32'd0);
    check("reset_done",   32'(done),   32'd0);
    check("reset_count",  32'(count),  32'd0);
    check("reset_ready",  32'(ready),  32'd1);

    // Single 0xA5 frame from idle; input changes right after acceptance.
    a5_lit = 10'b1_10100101_0;
    t = cyc + 1;
    dv = 1'b1; din = 8'hA5;
    @(negedge clk);
    dv = 1'b0; din = 8'h5A;
    wait_cyc(t + 1);
    check("a5_pop_line_high", 32'(serial), 32'd1);
    check("a5_pop_count",     32'(count),  32'd0);
    wait_cyc(t + 2);
    check("a5_start_low",     32'(serial), 32'd0);
    check("a5_active_rise",   32'(active), 32'd1);
    for (int k = 0; k < 10; k++) begin
      wait_cyc(t + 2 + CPB * k + CPB / 2);
      check("a5_bit", 32'(serial), 32'(a5_lit[k]));
    end
    wait_cyc(t + 100);
    check("a5_done_early", 32'(done),   32'd0);
    check("a5_active_end", 32'(active), 32'd1);
    wait_cyc(t + 101);
    check("a5_done_pulse", 32'(done),   32'd1);
    check("a5_stop_high",  32'(serial), 32'd1);
    wait_cyc(t + 102);
    check("a5_done_clear", 32'(done),   32'd0);
    check("a5_active_off", 32'(active), 32'd0);
    wait_cyc(t + 104);
    decode(t, t + 103);
    exp_q = '{8'hA5};
    check_rx("a5_rx");

    // 0x00 then 0xFF back-to-back: two extra idle-high cycles between frames.
    wait_cyc(cyc + 5);
    bq = '{8'h00, 8'hFF};
    burst();
    t = t_burst;
    wait_cyc(t + 101);
    check("gap_stop_end",  32'(serial), 32'd1);
    wait_cyc(t + 102);
    check("gap_high_1",    32'(serial), 32'd1);
    wait_cyc(t + 103);
    check("gap_high_2",    32'(serial), 32'd1);
    wait_cyc(t + 104);
    check("gap_next_start", 32'(serial), 32'd0);
    wait_cyc(t + 104 + FRAME + 3);
    decode(t, cyc - 1);
    exp_q = '{8'h00, 8'hFF};
    check_rx("gap_rx");

    // Write coinciding with the idle pop at count 1.
    wait_cyc(cyc + 7);
    rb_a = 8'($urandom);
    rb_b = 8'($urandom);
    bq = '{rb_a, rb_b};
    burst();
    t = t_burst;
    check("simul_count_before", 32'(cnt_hist[t]), 32'd1);
    check("simul_count_hold",   32'(count),       32'd1);
    wait_cyc(t + 2 + 2 * (FRAME + 2) + 2);
    decode(t, cyc - 1);
    exp_q = '{rb_a, rb_b};
    check_rx("simul_rx");

    // Overfill: six writes, the last one hits a full FIFO and is dropped.
    wait_cyc(cyc + 3);
    bq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    burst();
    t = t_burst;
    check("full_count_hist", 32'(cnt_hist[t + 4]), 32'd4);
    check("full_ready_hist", 32'(rdy_hist[t + 4]), 32'd0);
    check("full_count_drop", 32'(count),           32'd4);
    check("full_ready_low",  32'(ready),           32'd0);
    wait_cyc(t + 2 + 5 * (FRAME + 2) + 2);
    decode(t, cyc - 1);
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    check_rx("full_rx");

    // Reset during DATA_BITS with two bytes queued, while a write is also offered.
    wait_cyc(cyc + 3);
    bq = '{8'h11, 8'h22, 8'h33};
    burst();
    t = t_burst;
    wait_cyc(t + 2 + CPB * 3 + 3);
    check("pre_rst_count", 32'(count), 32'd2);
    rst = 1'b1; dv = 1'b1; din = 8'h77;
    @(negedge clk);
    rst = 1'b0; dv = 1'b0;
    tr = cyc;
    check("rst_line_high", 32'(serial), 32'd1);
    check("rst_count",     32'(count),  32'd0);
    check("rst_ready",     32'(ready),  32'd1);
    check("rst_active",    32'(active), 32'd0);
    check("rst_done",      32'(done),   32'd0);
    wait_cyc(tr + 400);
    ones = 0;
    dones = 0;
    for (int i = tr; i < tr + 399; i++) begin
      if (line_hist[i] === 1'b1) ones++;
      if (done_hist[i] !== 1'b0) dones++;
    end
    check("rst_line_idle", 32'(ones),  32'd399);
    check("rst_no_done",   32'(dones), 32'd0);

    // Randomized traffic: bursts of random length, random gaps, occasional resets.
    for (int it = 0; it < 40; it++) begin
      r = int'($urandom_range(0, 11));
      if (r == 0) begin
        rst = 1'b1;
        dv  = 1'($urandom);
        din = 8'($urandom);
        n = int'($urandom_range(1, 2));
        repeat (n) @(negedge clk);
        rst = 1'b0;
        dv  = 1'b0;
      end else begin
        n = int'($urandom_range(1, 6));
        bq.delete();
        repeat (n) bq.push_back(8'($urandom));
        burst();
      end
      gap = int'($urandom_range(0, 260));
      repeat (gap) @(negedge clk);
    end

    budget = 0;
    while ((pend.size() != 0 || (cur_valid && cyc <= cur_start + FRAME + 2)) && budget < 3000) begin
      @(negedge clk);
      budget++;
    end
    check("drain_in_time", 32'(budget < 3000), 32'd1);
    check("drain_count",   32'(count),          32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
